// File: rtl/usb_hs_rx_deframer_if.sv
// usb_hs_rx_deframer_if: line-side inputs and packet-side byte stream of the HS receive deframer
interface usb_hs_rx_deframer_if;
  logic       data_in;
  logic       bit_valid;
  logic       squelch;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;
  modport master (input data_in, bit_valid, squelch, output rx_data, rx_valid, rx_active, rx_eop, rx_error);
  modport slave (output data_in, bit_valid, squelch, input rx_data, rx_valid, rx_active, rx_eop, rx_error);
endinterface

// File: rtl/usb_hs_rx_deframer.sv
// usb_hs_rx_deframer: SYNC hunt, NRZI decode, bit unstuffing, HS EOP detection and byte assembly
module usb_hs_rx_deframer #(
  parameter int SYNC_MIN_ZEROS = 12,
  parameter int MAX_PKT_BYTES  = 1027,
  parameter int CNT_W          = 11
) (
  input logic                 clock_480,
  input logic                 reset_n,
  usb_hs_rx_deframer_if.master rx
);
  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  typedef enum logic [1:0] {IDLE, HUNT, DATA, ABORT} state_t;
  state_t state, state_n;
  logic prev_line, prev_n;
  logic [ZW-1:0] zero_cnt, zero_n;
  logic [2:0] ones_cnt, ones_n, bit_cnt, bit_n;
  logic [CNT_W-1:0] byte_cnt, byte_n;
  logic [7:0] sr, sr_n, data_q, data_n;
  logic valid_q, valid_n, active_q, active_n, eop_q, eop_n, err_q, err_n;
  logic dbit;
  logic [7:0] shifted;
  assign dbit    = ~(rx.data_in ^ prev_line);
  assign shifted = {dbit, sr[7:1]};
  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_active = active_q;
  assign rx.rx_eop    = eop_q;
  assign rx.rx_error  = err_q;
  // State and datapath registers; idle line is J, so prev_line resets high
  always_ff @(posedge clock_480 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prev_line <= 1'b1;
      zero_cnt  <= '0;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sr        <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      prev_line <= prev_n;
      zero_cnt  <= zero_n;
      ones_cnt  <= ones_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      sr        <= sr_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      active_q  <= active_n;
      eop_q     <= eop_n;
      err_q     <= err_n;
    end
  end
  // Next-state logic; everything but the strobes holds when no bit is offered
  always_comb begin
    state_n  = state;
    prev_n   = prev_line;
    zero_n   = zero_cnt;
    ones_n   = ones_cnt;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    sr_n     = sr;
    data_n   = data_q;
    valid_n  = 1'b0;
    active_n = active_q;
    eop_n    = 1'b0;
    err_n    = 1'b0;
    if (rx.bit_valid) begin
      prev_n = rx.data_in;
      case (state)
        IDLE: begin
          zero_n  = '0;
          state_n = rx.squelch ? IDLE : HUNT;
        end
        HUNT: begin
          if (rx.squelch) state_n = IDLE;
          else if (!dbit) zero_n = (zero_cnt == ZW'(SYNC_MIN_ZEROS)) ? zero_cnt : zero_cnt + ZW'(1);
          else if (zero_cnt >= ZW'(SYNC_MIN_ZEROS)) begin
            state_n  = DATA;
            active_n = 1'b1;
            bit_n    = '0;
            ones_n   = '0;
            byte_n   = '0;
          end else zero_n = '0;
        end
        DATA: begin
          if (rx.squelch || byte_cnt > CNT_W'(MAX_PKT_BYTES)) begin
            err_n    = 1'b1;
            active_n = 1'b0;
            state_n  = rx.squelch ? IDLE : ABORT;
          end else if (ones_cnt == 3'd6) begin
            ones_n = '0;
            if (dbit) begin
              eop_n    = byte_cnt != '0;
              err_n    = byte_cnt == '0;
              active_n = 1'b0;
              state_n  = IDLE;
            end
          end else begin
            sr_n   = shifted;
            ones_n = dbit ? ones_cnt + 3'd1 : '0;
            bit_n  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_n  = shifted;
              valid_n = 1'b1;
              byte_n  = byte_cnt + CNT_W'(1);
            end
          end
        end
        ABORT: begin
          if (rx.squelch || (ones_cnt == 3'd6 && dbit)) state_n = IDLE;
          else ones_n = dbit ? ones_cnt + 3'd1 : '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_hs_rx_deframer.sv
// tb_usb_hs_rx_deframer: directed and random packets checked against a packet-level reference model
module tb_usb_hs_rx_deframer;
  localparam int MINZ = 12;
  localparam int MAXB = 1027;
  logic clock_480 = 1'b0;
  logic reset_n = 1'b0;
  usb_hs_rx_deframer_if bus ();
  usb_hs_rx_deframer dut (.clock_480(clock_480), .reset_n(reset_n), .rx(bus));
  always #5 clock_480 = ~clock_480;
  int chk = 0, errs = 0;
  logic line = 1'b1;
  logic [7:0] pl[$];
  logic [7:0] got[$];
  bit stream[$];
  int sidx, n_eop, n_err, act_cyc, eop_at, gcnt;
  bit gap_on;
  task automatic check(input string tag, input int obs, input int exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Packet-side monitor, sampled on the falling edge
  always @(negedge clock_480) begin
    if (bus.rx_valid) got.push_back(bus.rx_data);
    if (bus.rx_eop) eop_at = got.size();
    n_eop += int'(bus.rx_eop);
    n_err += int'(bus.rx_error);
    act_cyc += int'(bus.rx_active);
    if (bus.rx_valid || bus.rx_eop || bus.rx_error)
      check("strobe_excl", int'(bus.rx_valid) + int'(bus.rx_eop) + int'(bus.rx_error), 1);
  end
  task automatic drive(input logic d, input logic sq, input logic bv);
    @(posedge clock_480);
    #1;
    bus.data_in = d;
    bus.squelch = sq;
    bus.bit_valid = bv;
  endtask
  task automatic send_dbit(input bit b, input bit sq);
    if (gap_on) begin
      gcnt++;
      if (gcnt % 5 == 0) drive(logic'($urandom % 2), sq, 1'b0);
    end
    line = b ? line : ~line;
    drive(line, sq, 1'b1);
  endtask
  task automatic clr();
    got.delete();
    n_eop = 0;
    n_err = 0;
    act_cyc = 0;
    eop_at = -1;
  endtask
  // Idle J, SYNC zeros + 1, stuffed payload LSB first, then EOP byte 0x7F unstuffed
  task automatic mk_stream(input int zeros);
    int run;
    stream.delete();
    repeat (4) stream.push_back(1'b1);
    repeat (zeros) stream.push_back(1'b0);
    sidx = stream.size();
    stream.push_back(1'b1);
    run = 0;
    foreach (pl[j]) for (int b = 0; b < 8; b++) begin
      stream.push_back(pl[j][b]);
      run = pl[j][b] ? run + 1 : 0;
      if (run == 6) begin
        stream.push_back(1'b0);
        run = 0;
      end
    end
    repeat (7) stream.push_back(1'b1);
    stream.push_back(1'b0);
  endtask
  task automatic run_pkt(input int zeros, input bit gaps, input int cut);
    mk_stream(zeros);
    clr();
    gap_on = gaps;
    for (int i = 0; i < stream.size(); i++) send_dbit(stream[i], cut >= 0 && i > sidx + cut);
    repeat (3) send_dbit(1'b1, 1'b1);
    gap_on = 0;
  endtask
  // Expected result from the packet rules: whole bytes out, EOP vs error, babble cap, active span
  task automatic model_check(input int zeros, input bit chk_act);
    int n, keep, run, vidx;
    bit q, babble;
    n = pl.size();
    q = zeros >= MINZ;
    babble = n > MAXB;
    keep = q ? (babble ? MAXB + 1 : n) : 0;
    check("nbytes", got.size(), keep);
    for (int i = 0; i < keep && i < got.size(); i++) check("byte", int'(got[i]), int'(pl[i]));
    check("eop", n_eop, int'(q && n >= 1 && !babble));
    check("error", n_err, int'(q && (n == 0 || babble)));
    if (q && n >= 1 && !babble) check("eop_order", eop_at, n);
    if (chk_act) begin
      run = 0;
      vidx = 0;
      for (int i = sidx + 1; i < stream.size() && vidx == 0; i++) begin
        run = stream[i] ? run + 1 : 0;
        if (run == 7) vidx = i;
      end
      check("active_span", act_cyc, q ? vidx - sidx : 0);
    end
  endtask
  initial begin
    bus.data_in = 1'b1;
    bus.squelch = 1'b1;
    bus.bit_valid = 1'b0;
    repeat (3) @(posedge clock_480);
    #1;
    check("rst_active", int'(bus.rx_active), 0);
    check("rst_valid", int'(bus.rx_valid), 0);
    check("rst_data", int'(bus.rx_data), 0);
    check("rst_eop_err", int'(bus.rx_eop) + int'(bus.rx_error), 0);
    reset_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 1'b1);
    pl = '{8'hC3, 8'hA5};
    run_pkt(31, 0, -1);
    model_check(31, 1);
    pl = '{8'hFF, 8'h3F};
    run_pkt(31, 0, -1);
    model_check(31, 1);
    pl = '{8'hC3, 8'hA5};
    run_pkt(8, 0, -1);
    model_check(8, 1);
    run_pkt(11, 0, -1);
    model_check(11, 1);
    run_pkt(12, 0, -1);
    model_check(12, 1);
    run_pkt(31, 0, 3);
    check("sq_nbytes", got.size(), 0);
    check("sq_error", n_err, 1);
    check("sq_eop", n_eop, 0);
    check("sq_active", act_cyc, 4);
    pl.delete();
    run_pkt(31, 0, -1);
    model_check(31, 1);
    pl = '{8'hC3, 8'hA5};
    run_pkt(31, 1, -1);
    model_check(31, 0);
    for (int k = 0; k < 10; k++) begin
      int z;
      z = int'($urandom_range(MINZ, 31));
      pl.delete();
      repeat ($urandom_range(0, 6)) pl.push_back(($urandom % 3 == 0) ? 8'hFF : 8'($urandom));
      run_pkt(z, bit'($urandom % 2), -1);
      model_check(z, 0);
    end
    pl = '{8'hC3, 8'hA5};
    mk_stream(31);
    clr();
    for (int i = 0; i <= sidx + 5; i++) send_dbit(stream[i], 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_active", int'(bus.rx_active), 0);
    check("mid_rst_data", int'(bus.rx_data), 0);
    check("mid_rst_strobes", int'(bus.rx_valid) + int'(bus.rx_eop) + int'(bus.rx_error), 0);
    line = 1'b1;
    bus.squelch = 1'b1;
    repeat (2) @(posedge clock_480);
    #1;
    reset_n = 1'b1;
    check("mid_rst_nbytes", got.size(), 0);
    run_pkt(31, 0, -1);
    model_check(31, 1);
    pl.delete();
    repeat (MAXB) pl.push_back(8'($urandom));
    run_pkt(20, 0, -1);
    model_check(20, 0);
    pl.push_back(8'h5A);
    run_pkt(20, 0, -1);
    model_check(20, 0);
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
